// File: rtl/control_pkg.sv
// control_pkg: opcode/funct/ALU constants, state encoding and strobe bundle for the multicycle control FSM.
// The TRAP state exists only when OVERFLOW_TRAP_EN is defined.
package control_pkg;
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_SLT   = 6'h2A;
   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_EXEC_R   = 4'd2,
      S_WB_R     = 4'd3,
      S_MEM_ADDR = 4'd4,
      S_MEM_RD   = 4'd5,
      S_WB_LW    = 4'd6,
      S_MEM_WR   = 4'd7,
      S_BRANCH   = 4'd8
`ifdef OVERFLOW_TRAP_EN
      , S_TRAP   = 4'd9
`endif
   } state_t;
   typedef struct packed {
      logic       irWrite;
      logic       pcWrite;
      logic       PCSrc;
      logic       regDst;
      logic       regWrite;
      logic       ALUSrc;
      logic [3:0] ALUcontrol;
      logic       memRead;
      logic       memWrite;
      logic       memToReg;
      logic       illegal;
   } ctrl_t;
endpackage

// File: rtl/multicycle_control_fsm_if.sv
// multicycle_control_fsm_if: instruction/flag inputs and control strobes between datapath and control FSM.
interface multicycle_control_fsm_if #(parameter int CNT_W = 16);
   logic [5:0]       i_opcode;
   logic [5:0]       i_funct;
   logic             i_isZero;
   logic             i_isOverflow;
   logic             i_memReady;
   logic             o_irWrite;
   logic             o_pcWrite;
   logic             o_PCSrc;
   logic             o_regDst;
   logic             o_regWrite;
   logic             o_ALUSrc;
   logic [3:0]       o_ALUcontrol;
   logic             o_memRead;
   logic             o_memWrite;
   logic             o_memToReg;
   logic             o_illegal;
   logic [CNT_W-1:0] o_instCount;
   logic [3:0]       o_state;
   modport slave (
      input  i_opcode, i_funct, i_isZero, i_isOverflow, i_memReady,
      output o_irWrite, o_pcWrite, o_PCSrc, o_regDst, o_regWrite, o_ALUSrc, o_ALUcontrol,
             o_memRead, o_memWrite, o_memToReg, o_illegal, o_instCount, o_state
   );
   modport master (
      output i_opcode, i_funct, i_isZero, i_isOverflow, i_memReady,
      input  o_irWrite, o_pcWrite, o_PCSrc, o_regDst, o_regWrite, o_ALUSrc, o_ALUcontrol,
             o_memRead, o_memWrite, o_memToReg, o_illegal, o_instCount, o_state
   );
endinterface

// File: rtl/alu_control_decoder.sv
// alu_control_decoder: R-type funct to ALU operation code plus legality flag.
module alu_control_decoder
   import control_pkg::*;
(
   input  logic [5:0] i_funct,
   output logic [3:0] o_ALUcontrol,
   output logic       o_legal
);
   assign o_ALUcontrol = i_funct == FN_ADD ? ALU_ADD :
                         i_funct == FN_SUB ? ALU_SUB :
                         i_funct == FN_AND ? ALU_AND :
                         i_funct == FN_OR  ? ALU_OR  :
                         i_funct == FN_SLT ? ALU_SLT : ALU_AND;
   assign o_legal = i_funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer with retired-instruction counter.
// Define OVERFLOW_TRAP_EN to trap add/sub overflow in WB_R into a sticky TRAP state.
module multicycle_control_fsm
   import control_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input logic i_clk,
   input logic i_rst,
   multicycle_control_fsm_if.slave bus
);
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic             inc;
   ctrl_t            c, out;
   logic [3:0]       alu_fn;
   logic             fn_legal;
   logic             is_r, is_lw, is_sw, is_beq;
   alu_control_decoder u_dec (
      .i_funct      (bus.i_funct),
      .o_ALUcontrol (alu_fn),
      .o_legal      (fn_legal)
   );
   assign is_r   = bus.i_opcode == OP_RTYPE;
   assign is_lw  = bus.i_opcode == OP_LW;
   assign is_sw  = bus.i_opcode == OP_SW;
   assign is_beq = bus.i_opcode == OP_BEQ;
`ifdef OVERFLOW_TRAP_EN
   logic trap;
   assign trap = (bus.i_funct == FN_ADD || bus.i_funct == FN_SUB) && bus.i_isOverflow;
`else
   logic unused_ovf;
   assign unused_ovf = bus.i_isOverflow;
`endif
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_q + CNT_W'(inc);
      end
   end
   always_comb begin
      c       = '0;
      state_d = S_FETCH;
      inc     = 1'b0;
      case (state_q)
         S_FETCH: begin
            c.irWrite = 1'b1;
            c.pcWrite = 1'b1;
            state_d   = S_DECODE;
         end
         S_DECODE: begin
            state_d   = (is_r && fn_legal) ? S_EXEC_R : (is_lw || is_sw) ? S_MEM_ADDR : is_beq ? S_BRANCH : S_FETCH;
            c.illegal = !((is_r && fn_legal) || is_lw || is_sw || is_beq);
         end
         S_EXEC_R: begin
            c.ALUcontrol = alu_fn;
            state_d      = S_WB_R;
         end
         S_WB_R: begin
            c.regDst     = 1'b1;
            c.regWrite   = 1'b1;
            c.ALUcontrol = alu_fn;
            inc          = 1'b1;
`ifdef OVERFLOW_TRAP_EN
            if (trap) begin
               c.regWrite = 1'b0;
               inc        = 1'b0;
               state_d    = S_TRAP;
            end
`endif
         end
         S_MEM_ADDR: begin
            c.ALUSrc     = 1'b1;
            c.ALUcontrol = ALU_ADD;
            state_d      = is_lw ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            c.memRead    = 1'b1;
            c.ALUSrc     = 1'b1;
            c.ALUcontrol = ALU_ADD;
            state_d      = bus.i_memReady ? S_WB_LW : S_MEM_RD;
         end
         S_WB_LW: begin
            c.memToReg   = 1'b1;
            c.regWrite   = 1'b1;
            c.memRead    = 1'b1;
            c.ALUSrc     = 1'b1;
            c.ALUcontrol = ALU_ADD;
            inc          = 1'b1;
         end
         S_MEM_WR: begin
            c.memWrite   = 1'b1;
            c.ALUSrc     = 1'b1;
            c.ALUcontrol = ALU_ADD;
            state_d      = bus.i_memReady ? S_FETCH : S_MEM_WR;
            inc          = bus.i_memReady;
         end
         S_BRANCH: begin
            c.ALUcontrol = ALU_SUB;
            c.PCSrc      = 1'b1;
            c.pcWrite    = bus.i_isZero;
            inc          = 1'b1;
         end
`ifdef OVERFLOW_TRAP_EN
         S_TRAP: begin
            c.illegal = 1'b1;
            state_d   = S_TRAP;
         end
`endif
         default: ;
      endcase
   end
   // Strobes are held low while reset is asserted, even before the first edge lands.
   assign out              = i_rst ? '0 : c;
   assign bus.o_irWrite    = out.irWrite;
   assign bus.o_pcWrite    = out.pcWrite;
   assign bus.o_PCSrc      = out.PCSrc;
   assign bus.o_regDst     = out.regDst;
   assign bus.o_regWrite   = out.regWrite;
   assign bus.o_ALUSrc     = out.ALUSrc;
   assign bus.o_ALUcontrol = out.ALUcontrol;
   assign bus.o_memRead    = out.memRead;
   assign bus.o_memWrite   = out.memWrite;
   assign bus.o_memToReg   = out.memToReg;
   assign bus.o_illegal    = out.illegal;
   assign bus.o_instCount  = cnt_q;
   assign bus.o_state      = state_q;
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: randomized instruction stream against a per-instruction cycle-sequence model.
// Define OVERFLOW_TRAP_EN to also exercise the overflow trap.
module tb_multicycle_control_fsm;
   localparam int CW = 4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   multicycle_control_fsm_if #(.CNT_W(CW)) bus();
   multicycle_control_fsm #(.CNT_W(CW)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
   int checks = 0;
   int errors = 0;
   int model_cnt = 0;
   logic [17:0] exp_q[$];
   int rdy_q[$];
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask
   function automatic logic [17:0] obs();
      return {bus.o_state, bus.o_irWrite, bus.o_pcWrite, bus.o_PCSrc, bus.o_regDst, bus.o_regWrite,
              bus.o_ALUSrc, bus.o_ALUcontrol, bus.o_memRead, bus.o_memWrite, bus.o_memToReg, bus.o_illegal};
   endfunction
   // a = {irWrite,pcWrite,PCSrc,regDst,regWrite,ALUSrc}, b = {memRead,memWrite,memToReg,illegal}
   function automatic logic [17:0] rec(input logic [3:0] st, input logic [5:0] a, input logic [3:0] alu, input logic [3:0] b);
      return {st, a, alu, b};
   endfunction
   function automatic logic [4:0] fn_info(input logic [5:0] fn);
      case (fn)
         6'h20: return {1'b1, 4'b0010};
         6'h22: return {1'b1, 4'b0110};
         6'h24: return {1'b1, 4'b0000};
         6'h25: return {1'b1, 4'b0001};
         6'h2A: return {1'b1, 4'b0111};
         default: return 5'b0;
      endcase
   endfunction
   task automatic push(input logic [17:0] e, input int r);
      exp_q.push_back(e);
      rdy_q.push_back(r);
   endtask
   // Expected cycle-by-cycle trace of one instruction; returns whether it retires.
   task automatic build(input logic [5:0] op, input logic [5:0] fn, input int waits, input logic zero, output bit counted);
      logic [4:0] fi;
      fi = fn_info(fn);
      counted = 1'b1;
      push(rec(4'd0, 6'b110000, 4'b0, 4'b0), 2);
      if (op == 6'h00 && fi[4]) begin
         push(rec(4'd1, 6'b0, 4'b0, 4'b0), 2);
         push(rec(4'd2, 6'b0, fi[3:0], 4'b0), 2);
         push(rec(4'd3, 6'b000110, fi[3:0], 4'b0), 2);
      end else if (op == 6'h23) begin
         push(rec(4'd1, 6'b0, 4'b0, 4'b0), 2);
         push(rec(4'd4, 6'b000001, 4'b0010, 4'b0), 2);
         for (int i = 0; i < waits; i++) push(rec(4'd5, 6'b000001, 4'b0010, 4'b1000), 0);
         push(rec(4'd5, 6'b000001, 4'b0010, 4'b1000), 1);
         push(rec(4'd6, 6'b000011, 4'b0010, 4'b1010), 2);
      end else if (op == 6'h2B) begin
         push(rec(4'd1, 6'b0, 4'b0, 4'b0), 2);
         push(rec(4'd4, 6'b000001, 4'b0010, 4'b0), 2);
         for (int i = 0; i < waits; i++) push(rec(4'd7, 6'b000001, 4'b0010, 4'b0100), 0);
         push(rec(4'd7, 6'b000001, 4'b0010, 4'b0100), 1);
      end else if (op == 6'h04) begin
         push(rec(4'd1, 6'b0, 4'b0, 4'b0), 2);
         push(rec(4'd8, {1'b0, zero, 1'b1, 3'b0}, 4'b0110, 4'b0), 2);
      end else begin
         push(rec(4'd1, 6'b0, 4'b0, 4'b0001), 2);
         counted = 1'b0;
      end
   endtask
   task automatic run_queue(input string tag);
      logic [17:0] e;
      int r;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         r = rdy_q.pop_front();
         bus.i_memReady = (r == 2) ? 1'($urandom_range(0, 1)) : 1'(r);
         #1;
         check(tag, 32'(obs()), 32'(e));
         @(posedge clk);
         #1;
      end
   endtask
   task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input int waits, input logic zero, input logic ovf);
      bit counted;
      bus.i_opcode     = op;
      bus.i_funct      = fn;
      bus.i_isZero     = zero;
      bus.i_isOverflow = ovf;
      build(op, fn, waits, zero, counted);
      run_queue($sformatf("op%02h_fn%02h", op, fn));
      if (counted) model_cnt = (model_cnt + 1) % (1 << CW);
      check("count", 32'(bus.o_instCount), 32'(model_cnt));
   endtask
   logic [5:0] legal_fn[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
   logic ovf_rand;
   initial begin
      bus.i_opcode     = 6'h00;
      bus.i_funct      = 6'h20;
      bus.i_isZero     = 1'b0;
      bus.i_isOverflow = 1'b0;
      bus.i_memReady   = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out", 32'(obs()), 32'(rec(4'd0, 6'b0, 4'b0, 4'b0)));
      check("rst_cnt", 32'(bus.o_instCount), 32'd0);
      rst = 1'b0;
      do_instr(6'h00, 6'h20, 0, 1'b0, 1'b0);
      do_instr(6'h23, 6'h00, 3, 1'b0, 1'b0);
      do_instr(6'h04, 6'h11, 0, 1'b1, 1'b0);
      do_instr(6'h04, 6'h11, 0, 1'b0, 1'b0);
      do_instr(6'h3F, 6'h20, 0, 1'b0, 1'b0);
      do_instr(6'h00, 6'h00, 0, 1'b0, 1'b0);
      do_instr(6'h2B, 6'h00, 0, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) do_instr(6'h00, legal_fn[i % 5], 0, 1'b0, 1'b0);
      for (int i = 0; i < 200; i++) begin
         logic [5:0] op, fn;
         int k;
         k  = $urandom_range(0, 5);
         fn = legal_fn[$urandom_range(0, 4)];
         op = 6'h00;
         if (k == 1) op = 6'h23;
         if (k == 2) op = 6'h2B;
         if (k == 3) op = 6'h04;
         if (k == 4) begin
            op = 6'($urandom);
            while (op inside {6'h00, 6'h23, 6'h2B, 6'h04}) op = 6'($urandom);
         end
         if (k == 5) begin
            fn = 6'($urandom);
            while (fn_info(fn) != 5'b0) fn = 6'($urandom);
         end
`ifdef OVERFLOW_TRAP_EN
         ovf_rand = 1'b0;
`else
         ovf_rand = 1'($urandom_range(0, 1));
`endif
         do_instr(op, fn, $urandom_range(0, 3), 1'($urandom_range(0, 1)), ovf_rand);
      end
      // Abort a store stalled in MEM_WR with reset.
      bus.i_opcode = 6'h2B;
      push(rec(4'd0, 6'b110000, 4'b0, 4'b0), 2);
      push(rec(4'd1, 6'b0, 4'b0, 4'b0), 2);
      push(rec(4'd4, 6'b000001, 4'b0010, 4'b0), 2);
      run_queue("sw_abort");
      bus.i_memReady = 1'b0;
      #1;
      check("mem_wr", 32'(obs()), 32'(rec(4'd7, 6'b000001, 4'b0010, 4'b0100)));
      rst = 1'b1;
      #1;
      check("rst_gate", 32'(obs()), 32'(rec(4'd7, 6'b0, 4'b0, 4'b0)));
      @(posedge clk);
      #1;
      check("rst_state", 32'(obs()), 32'(rec(4'd0, 6'b0, 4'b0, 4'b0)));
      check("rst_cnt2", 32'(bus.o_instCount), 32'd0);
      rst = 1'b0;
      model_cnt = 0;
      do_instr(6'h00, 6'h25, 0, 1'b0, 1'b0);
`ifdef OVERFLOW_TRAP_EN
      bus.i_opcode     = 6'h00;
      bus.i_funct      = 6'h20;
      bus.i_isOverflow = 1'b1;
      push(rec(4'd0, 6'b110000, 4'b0, 4'b0), 2);
      push(rec(4'd1, 6'b0, 4'b0, 4'b0), 2);
      push(rec(4'd2, 6'b0, 4'b0010, 4'b0), 2);
      push(rec(4'd3, 6'b000100, 4'b0010, 4'b0), 2);
      for (int i = 0; i < 5; i++) push(rec(4'd9, 6'b0, 4'b0, 4'b0001), 2);
      run_queue("trap");
      check("trap_cnt", 32'(bus.o_instCount), 32'(model_cnt));
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.i_isOverflow = 1'b0;
      model_cnt = 0;
      do_instr(6'h00, 6'h22, 0, 1'b0, 1'b0);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
